// File: rtl/gm_pkg.sv
// rtl/gm_pkg.sv - shared constants and state type for the object draw path
package gm_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int ADDR_W    = 4;
  localparam int TYPE_W    = 5;

  // Type codes shared with draw_object_control
  localparam logic [TYPE_W-1:0] OBJ_TYPE_NONE   = 5'd0;
  localparam logic [TYPE_W-1:0] OBJ_TYPE_SPRITE = 5'd1;
  localparam logic [TYPE_W-1:0] OBJ_TYPE_TEXT   = 5'd2;
  localparam logic [TYPE_W-1:0] OBJ_TYPE_RECT   = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_LATCH,
    S_REQ,
    S_RELEASE,
    S_NEXT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/object_draw_sequencer_slot_counter.sv
// rtl/object_draw_sequencer_slot_counter.sv - slot index up-counter with clear, enable and last flag
module slot_counter #(
  parameter int ADDR_W = 4,
  parameter int LAST   = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              enable_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] count_q;

  assign last_o  = (count_q == ADDR_W'(LAST));
  assign count_o = count_q;

  // Count up on enable; saturate at the last slot so a pass can never wrap
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !last_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/object_draw_sequencer.sv
// rtl/object_draw_sequencer.sv - walks valid object slots and hands each to the draw FSM
module object_draw_sequencer
  import gm_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              start_scene,
  input  logic              initial_frame,
  input  logic [15:0]       slot_valid,
  input  logic [TYPE_W-1:0] tbl_type,
  input  logic              draw_object_done,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [ADDR_W-1:0] object_location_address,
  output logic [TYPE_W-1:0] object_type,
  output logic              start_draw_object,
  output logic              start_initial_module,
  output logic              busy,
  output logic              scene_done
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] slot;
  logic              slot_last;
  logic              accept;

  logic [ADDR_W-1:0] location_q;
  logic [TYPE_W-1:0] type_q;
  logic              start_q;
  logic              initial_q;
  logic              busy_q;
  logic              done_q;

  assign accept = (state_q == S_IDLE) && start_scene;

  slot_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (NUM_SLOTS - 1)
  ) u_slot_counter (
    .clock    (clock),
    .resetn   (resetn),
    .clear_i  (accept),
    .enable_i (state_q == S_NEXT),
    .count_o  (slot),
    .last_o   (slot_last)
  );

  // Table address follows the slot counter; data is valid one cycle later in S_LATCH
  assign tbl_addr                = slot;
  assign object_location_address = location_q;
  assign object_type             = type_q;
  assign start_draw_object       = start_q;
  assign start_initial_module    = initial_q;
  assign busy                    = busy_q;
  assign scene_done              = done_q;

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: scan each slot once, handshake on valid ones, stop after the last slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_scene) state_d = S_SCAN;
      S_SCAN:    state_d = slot_valid[slot] ? S_READ : S_NEXT;
      S_READ:    state_d = S_LATCH;
      S_LATCH:   state_d = S_REQ;
      S_REQ:     if (draw_object_done) state_d = S_RELEASE;
      S_RELEASE: if (!draw_object_done) state_d = S_NEXT;
      S_NEXT:    state_d = slot_last ? S_DONE : S_SCAN;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered outputs and per-object latches; fields change only outside S_REQ
  always_ff @(posedge clock) begin
    if (!resetn) begin
      location_q <= '0;
      type_q     <= '0;
      start_q    <= 1'b0;
      initial_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= (state_q == S_REQ);
      done_q  <= (state_q == S_DONE);
      if (accept) begin
        initial_q <= initial_frame;
        busy_q    <= 1'b1;
      end
      if (state_q == S_DONE) begin
        busy_q <= 1'b0;
      end
      if (state_q == S_LATCH) begin
        type_q     <= tbl_type;
        location_q <= slot;
      end
    end
  end

endmodule

// File: tb/tb_object_draw_sequencer.sv
// tb/tb_object_draw_sequencer.sv - randomized and directed bench for object_draw_sequencer
module tb_object_draw_sequencer;
  import gm_pkg::*;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start_scene = 1'b0;
  logic              initial_frame = 1'b0;
  logic [15:0]       slot_valid = '0;
  logic [TYPE_W-1:0] tbl_type = '0;
  logic              draw_object_done = 1'b0;
  logic [ADDR_W-1:0] tbl_addr;
  logic [ADDR_W-1:0] object_location_address;
  logic [TYPE_W-1:0] object_type;
  logic              start_draw_object;
  logic              start_initial_module;
  logic              busy;
  logic              scene_done;

  logic [TYPE_W-1:0] tbl_mem [NUM_SLOTS];
  int                cycle = 0;
  int                vectors = 0;
  int                miscompares = 0;
  int                resp_delay = 2;

  logic [31:0] rec_addr [$];
  logic [31:0] rec_type [$];
  logic [31:0] rec_init [$];
  int          done_pulses;
  int          done_cycle;
  int          stable_err;
  logic        sim_at_done;

  object_draw_sequencer dut (
    .clock                   (clock),
    .resetn                  (resetn),
    .start_scene             (start_scene),
    .initial_frame           (initial_frame),
    .slot_valid              (slot_valid),
    .tbl_type                (tbl_type),
    .draw_object_done        (draw_object_done),
    .tbl_addr                (tbl_addr),
    .object_location_address (object_location_address),
    .object_type             (object_type),
    .start_draw_object       (start_draw_object),
    .start_initial_module    (start_initial_module),
    .busy                    (busy),
    .scene_done              (scene_done)
  );

  always #5 clock = ~clock;

  // Cycle counter
  always @(posedge clock) cycle <= cycle + 1;

  // Object table with one cycle read latency
  always @(posedge clock) tbl_type <= tbl_mem[tbl_addr];

  // Draw FSM stand-in: raise done resp_delay cycles after start, drop it after start drops
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        draw_object_done = 1'b0;
        cnt = 0;
      end else if (start_draw_object && !draw_object_done) begin
        cnt++;
        if (cnt >= resp_delay) draw_object_done = 1'b1;
      end else if (!start_draw_object && draw_object_done) begin
        draw_object_done = 1'b0;
        cnt = 0;
      end
    end
  end

  // Observer: record each handshake, field stability and scene_done pulses
  initial begin
    logic              prev_start;
    logic [ADDR_W-1:0] h_addr;
    logic [TYPE_W-1:0] h_type;
    logic              h_init;
    prev_start = 1'b0;
    h_addr = '0;
    h_type = '0;
    h_init = 1'b0;
    forever begin
      @(negedge clock);
      if (start_draw_object && !prev_start) begin
        rec_addr.push_back(32'(object_location_address));
        rec_type.push_back(32'(object_type));
        rec_init.push_back(32'(start_initial_module));
      end else if (start_draw_object && prev_start) begin
        if (object_type != h_type || object_location_address != h_addr ||
            start_initial_module != h_init) stable_err++;
      end
      if (scene_done) begin
        done_pulses++;
        done_cycle  = cycle;
        sim_at_done = start_initial_module;
      end
      h_addr     = object_location_address;
      h_type     = object_type;
      h_init     = start_initial_module;
      prev_start = start_draw_object;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic fill_table();
    for (int i = 0; i < NUM_SLOTS; i++) tbl_mem[i] = TYPE_W'($urandom_range(0, 31));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tbl_addr"}, 32'(tbl_addr), 0);
    chk({tag, "_location"}, 32'(object_location_address), 0);
    chk({tag, "_type"}, 32'(object_type), 0);
    chk({tag, "_start"}, 32'(start_draw_object), 0);
    chk({tag, "_initial"}, 32'(start_initial_module), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_scene_done"}, 32'(scene_done), 0);
  endtask

  task automatic run_scene(input logic [15:0] valid, input logic init, input bit toggle,
                           input bit repulse, input int delay);
    int exp_addr [$];
    int waited;
    int accept_cycle;
    resp_delay = delay;
    rec_addr.delete();
    rec_type.delete();
    rec_init.delete();
    done_pulses = 0;
    stable_err  = 0;
    sim_at_done = ~init;
    step();
    slot_valid    = valid;
    initial_frame = init;
    start_scene   = 1'b1;
    step();
    start_scene  = 1'b0;
    accept_cycle = cycle;
    repeat (3) step();
    chk("busy_in_pass", 32'(busy), 1);
    if (toggle) initial_frame = ~init;
    if (repulse) begin
      start_scene = 1'b1;
      step();
      start_scene = 1'b0;
    end
    waited = 0;
    while (done_pulses == 0 && waited < 3000) begin
      step();
      waited++;
    end
    chk("scene_done_within_bound", 32'(done_pulses > 0), 1);
    repeat (6) step();
    for (int i = 0; i < NUM_SLOTS; i++) if (valid[i]) exp_addr.push_back(i);
    chk("handshake_count", rec_addr.size(), exp_addr.size());
    foreach (exp_addr[k]) begin
      if (k < rec_addr.size()) begin
        chk("handshake_addr", rec_addr[k], exp_addr[k]);
        chk("handshake_type", rec_type[k], 32'(tbl_mem[exp_addr[k]]));
        chk("handshake_initial", rec_init[k], 32'(init));
      end
    end
    chk("scene_done_pulses", done_pulses, 1);
    chk("fields_stable_during_start", stable_err, 0);
    chk("initial_at_scene_done", 32'(sim_at_done), 32'(init));
    chk("busy_after_pass", 32'(busy), 0);
    chk("start_after_pass", 32'(start_draw_object), 0);
    if (valid == 16'h0000) chk("empty_pass_length", done_cycle - accept_cycle, 2 * NUM_SLOTS + 1);
  endtask

  initial begin
    int waited;
    fill_table();
    resetn = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    resetn = 1'b1;
    step();

    // Empty scene: no handshakes, fixed pass length
    run_scene(16'h0000, 1'b0, 1'b0, 1'b0, 2);

    // Single object in slot 0 with type 10
    tbl_mem[0] = 5'd10;
    run_scene(16'h0001, 1'b0, 1'b0, 1'b0, 3);

    // First, middle and last slots
    fill_table();
    run_scene(16'h8005, 1'b1, 1'b0, 1'b0, 1);

    // initial_frame toggled after accept must not leak into the pass
    fill_table();
    run_scene(16'h0f0f, 1'b1, 1'b1, 1'b0, 2);

    // start_scene re-pulsed while busy is ignored
    fill_table();
    run_scene(16'h0420, 1'b0, 1'b0, 1'b1, 2);

    // Reset while start_draw_object is high
    resp_delay = 100000;
    step();
    slot_valid    = 16'h0001;
    initial_frame = 1'b1;
    start_scene   = 1'b1;
    step();
    start_scene = 1'b0;
    waited = 0;
    while (!start_draw_object && waited < 100) begin
      step();
      waited++;
    end
    chk("reached_start_before_reset", 32'(start_draw_object), 1);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("mid_handshake_reset");
    step();
    resetn = 1'b1;
    step();
    fill_table();
    run_scene(16'h0003, 1'b0, 1'b0, 1'b0, 2);

    // Randomized scenes
    repeat (8) begin
      fill_table();
      run_scene(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
